// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: word types, reset
// defaults and the fetch-stage state encoding.
package mips_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_e;

    // Sequential word address; wraps at the top of the 32-bit space.
    function automatic word_t next_word_addr(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a bubble overrides a load, otherwise the
// register holds.
module if_id_reg
    import mips_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  logic  load,
    input  word_t next_instr,
    input  word_t next_pc,
    output word_t instruction_id,
    output word_t pc_id,
    output logic  id_valid
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction_id <= NOP_INSTR;
            pc_id          <= '0;
            id_valid       <= 1'b0;
        end else if (bubble) begin
            // pc_id is left alone so the bubble keeps its neighbour's PC.
            instruction_id <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (load) begin
            instruction_id <= next_instr;
            pc_id          <= next_pc;
            id_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request port with a one-entry skid
// buffer, and a discard state for redirects while a fetch is outstanding.
module fetch_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  PcWrite,
    input  logic  if_idWrite,
    input  logic  if_idFlush,
    input  logic  pc_src,
    input  word_t address_out,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_ready,
    input  word_t imem_rdata,
    output word_t instruction_id,
    output word_t pc_id,
    output logic  id_valid,
    output word_t pc_if,
    output logic  fetch_stall
);

    fetch_state_e state, state_next;
    word_t        pc_next, req_addr, skid_instr, id_instr;
    logic         fire, advance, id_bubble, id_load, skid_capture;

    assign fire        = imem_req && imem_ready;
    assign advance     = PcWrite && if_idWrite;
    assign imem_addr   = (state == DISCARD) ? req_addr : pc_if;
    assign fetch_stall = (state == DISCARD) ||
                         ((state == FETCH) && imem_req && !imem_ready);

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_next   = state;
        pc_next      = pc_if;
        id_bubble    = if_idFlush;
        id_load      = 1'b0;
        id_instr     = imem_rdata;
        skid_capture = 1'b0;
        unique case (state)
            FETCH: begin
                if (pc_src) begin
                    pc_next   = address_out;
                    id_bubble = 1'b1;
                    if (imem_req && !imem_ready) state_next = DISCARD;
                end else if (fire) begin
                    if (advance) begin
                        id_load = 1'b1;
                        pc_next = next_word_addr(pc_if);
                    end else begin
                        skid_capture = 1'b1;
                        state_next   = BUFFERED;
                    end
                end else if (if_idWrite) begin
                    id_bubble = 1'b1;
                end
            end
            BUFFERED: begin
                // The PC is frozen here, so pc_if is still the buffered word's PC.
                if (pc_src) begin
                    pc_next    = address_out;
                    id_bubble  = 1'b1;
                    state_next = FETCH;
                end else if (advance) begin
                    id_load    = 1'b1;
                    id_instr   = skid_instr;
                    pc_next    = next_word_addr(pc_if);
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                if (if_idWrite || pc_src) id_bubble = 1'b1;
                if (pc_src) pc_next = address_out;
                if (fire) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // imem_req is registered so it stays low through reset and only rises
    // once the first clock edge after release has been taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc_if      <= RESET_PC;
            req_addr   <= RESET_PC;
            skid_instr <= '0;
            imem_req   <= 1'b0;
        end else begin
            state    <= state_next;
            pc_if    <= pc_next;
            imem_req <= (state_next != BUFFERED);
            if (state == FETCH) req_addr <= pc_if;
            if (skid_capture)   skid_instr <= imem_rdata;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .bubble        (id_bubble),
        .load          (id_load),
        .next_instr    (id_instr),
        .next_pc       (pc_if),
        .instruction_id(instruction_id),
        .pc_id         (pc_id),
        .id_valid      (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control/latency traffic checked by a scoreboard of expected deliveries.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam word_t RST_PC = 32'h0000_0000;
    localparam word_t NOP    = 32'h0000_0000;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  PcWrite, if_idWrite, if_idFlush, pc_src, imem_ready, imem_req;
    logic  id_valid, fetch_stall;
    word_t address_out, imem_rdata, imem_addr, instruction_id, pc_id, pc_if;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PcWrite       (PcWrite),
        .if_idWrite    (if_idWrite),
        .if_idFlush    (if_idFlush),
        .pc_src        (pc_src),
        .address_out   (address_out),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instruction_id(instruction_id),
        .pc_id         (pc_id),
        .id_valid      (id_valid),
        .pc_if         (pc_if),
        .fetch_stall   (fetch_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the decoder must see the program-order stream starting at the
    // last redirect target (or reset PC), each word being memory[pc].
    typedef struct packed {
        word_t pc;
        word_t instr;
    } exp_t;

    exp_t  exp_q[$];
    word_t tail_pc;
    word_t key = 32'h0;
    int    force_lat = 0;
    int    delivered = 0;

    function automatic void sb_fill();
        while (exp_q.size() < 32) begin
            exp_q.push_back('{pc: tail_pc, instr: tail_pc ^ key});
            tail_pc = tail_pc + 32'd4;
        end
    endfunction

    function automatic void sb_restart(input word_t start);
        exp_q.delete();
        tail_pc = start;
        sb_fill();
    endfunction

    // Memory model: one request at a time, word = address ^ key.
    initial begin : memory
        bit    pending = 0;
        int    cnt = 0;
        word_t lat_addr = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pending    = 0;
                imem_ready = 1'b0;
            end else begin
                if (pending) begin
                    check("req_held", 32'(imem_req), 32'd1);
                    check("addr_stable", imem_addr, lat_addr);
                    cnt--;
                end else if (imem_req) begin
                    pending  = 1;
                    lat_addr = imem_addr;
                    cnt      = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                end
                imem_ready = pending && (cnt == 0);
                imem_rdata = imem_ready ? (lat_addr ^ key) : 32'hDEAD_BEEF;
                if (imem_ready) pending = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever IF/ID loads a real instruction.
    initial begin : monitor
        bit    deliver_edge, live, prev_valid;
        word_t prev_pc, prev_instr;
        exp_t  e;
        prev_valid = 0;
        prev_pc    = '0;
        prev_instr = '0;
        forever begin
            @(posedge clk);
            deliver_edge = PcWrite && if_idWrite && !if_idFlush && !pc_src;
            live         = reset;
            #1;
            if (live && reset) begin
                if (id_valid && deliver_edge) begin
                    if (exp_q.size() == 0) begin
                        check("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliver_instr", instruction_id, e.instr);
                        check("deliver_pc", pc_id, e.pc);
                        delivered++;
                    end
                end else if (id_valid) begin
                    check("hold_valid", 32'(prev_valid), 32'd1);
                    check("hold_pc", pc_id, prev_pc);
                    check("hold_instr", instruction_id, prev_instr);
                end else begin
                    check("bubble_nop", instruction_id, NOP);
                end
                if (exp_q.size() > 0) check("pc_if_next", pc_if, exp_q[0].pc);
            end
            prev_valid = id_valid;
            prev_pc    = pc_id;
            prev_instr = instruction_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        sb_fill();
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl,
                         input logic ps, input word_t addr);
        PcWrite     = pw;
        if_idWrite  = iw;
        if_idFlush  = fl;
        pc_src      = ps;
        address_out = addr;
        if (ps) sb_restart(addr);
    endtask

    task automatic run_until_pc(input word_t target);
        int n = 0;
        while (pc_if !== target && n < 200) begin
            tick();
            n++;
        end
        check("reach_pc", pc_if, target);
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_rise", 32'(imem_req), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_instr"}, instruction_id, NOP);
        check({tag, "_pc_id"}, pc_id, 32'h0);
        check({tag, "_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_pc_if"}, pc_if, RST_PC);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        word_t pc0, pcid0, rnd, addr;
        int    start_delivered;
        logic  pw, iw, fl, ps;

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        sb_restart(RST_PC);
        repeat (2) tick();
        check_reset_values("rst");
        reset = 1'b1;

        // Zero-wait streaming: 0x0, 0x4, 0x8 on successive cycles.
        wait_req();
        repeat (3) tick();
        check("stream_instr", instruction_id, 32'h8);
        check("stream_valid", 32'(id_valid), 32'd1);
        check("stream_pc_if", pc_if, 32'h0C);

        // Load-use stall at 0x10 with the word returned: parked in the skid buffer.
        run_until_pc(32'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_instr", instruction_id, 32'h0C);
        check("stall_pc_if", pc_if, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("skid_instr", instruction_id, 32'h10);
        check("skid_pc_if", pc_if, 32'h14);
        check("skid_addr", imem_addr, 32'h14);

        // Taken branch at 0x20 to 0x40.
        run_until_pc(32'h20);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        tick();
        check("br_valid", 32'(id_valid), 32'd0);
        check("br_addr", imem_addr, 32'h40);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("br_instr", instruction_id, 32'h40);

        // Redirect to 0x80 while the 0x30 fetch waits three cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h30);
        tick();
        force_lat = 3;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        force_lat = 0;
        check("disc_addr1", imem_addr, 32'h30);
        check("disc_stall", 32'(fetch_stall), 32'd1);
        check("disc_pc_if", pc_if, 32'h80);
        check("disc_valid", 32'(id_valid), 32'd0);
        tick();
        check("disc_addr2", imem_addr, 32'h30);
        tick();
        check("disc_addr3", imem_addr, 32'h30);
        tick();
        check("disc_resume", imem_addr, 32'h80);
        tick();
        check("disc_instr", instruction_id, 32'h80);

        // Flush together with an IF/ID hold: bubble in, PC kept.
        pc0   = pc_if;
        pcid0 = pc_id;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("flush_valid", 32'(id_valid), 32'd0);
        check("flush_instr", instruction_id, NOP);
        check("flush_pc_if", pc_if, pc0);
        check("flush_pc_id", pc_id, pcid0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check("flush_resume", instruction_id, pc0);

        // PC wrap past the top of the address space.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        run_until_pc(32'hFFFF_FFFC);
        tick();
        check("wrap_pc_if", pc_if, 32'h0);
        check("wrap_instr", instruction_id, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of a discard.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        tick();
        force_lat = 3;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_rst_stall", 32'(fetch_stall), 32'd1);
        #1;
        reset = 1'b0;
        sb_restart(RST_PC);
        #1;
        check_reset_values("async_rst");
        check("async_rst_addr", imem_addr, RST_PC);
        check("async_rst_stall", 32'(fetch_stall), 32'd0);
        force_lat = 0;
        repeat (2) tick();
        reset = 1'b1;
        wait_req();
        tick();
        check("post_rst_instr", instruction_id, RST_PC);

        // Randomized controls and memory latency.
        force_lat       = -1;
        key             = 32'h3C3C_A5A4;
        start_delivered = delivered;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1000);
        tick();
        for (int i = 0; i < 3000; i++) begin
            pw  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 3) != 0);
            ps  = ($urandom_range(0, 11) == 0);
            fl  = ps ? 1'($urandom_range(0, 1))
                     : (!(pw && iw) && ($urandom_range(0, 3) == 0));
            rnd = $urandom();
            addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {rnd[31:2], 2'b00};
            drive(pw, iw, fl, ps, addr);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8) tick();
        check("rand_progress", 32'(delivered - start_delivered > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
